// File: rtl/reaction_sequencer.sv
// reaction_sequencer
// Round controller for the reaction game. Runs on the 500 Hz display clock
// (1 tick = 2 ms) and sequences IDLE -> ARM -> GO -> RESULT/FOUL.
// Ports:
//   clk_500Hz  : clock
//   rst        : asynchronous active-high reset
//   btn_start  : single-cycle start pulse
//   btn_react  : single-cycle reaction pulse
//   mode_sel   : 00 easy, 01 regular, 10/11 hard
//   number     : value for the numeric display (valid when select = 1)
//   select     : 0 = mode banner, 1 = numeric
//   mode       : latched mode (00/01/10)
//   led_go     : GO indicator
//   foul       : false-start flag
//   miss       : timeout flag
//   best       : best valid reaction time in ms
module reaction_sequencer #(
  parameter int WAIT_MIN_TICKS = 500,
  parameter int HOLD_TICKS     = 1500,
  parameter int TO_EASY_MS     = 2000,
  parameter int TO_REG_MS      = 1000,
  parameter int TO_HARD_MS     = 500,
  parameter int MISS_MS        = 8190
) (
  input  logic        clk_500Hz,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_react,
  input  logic [1:0]  mode_sel,
  output logic [12:0] number,
  output logic        select,
  output logic [1:0]  mode,
  output logic        led_go,
  output logic        foul,
  output logic        miss,
  output logic [12:0] best
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_GO     = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_FOUL   = 3'd4;

  localparam logic [12:0] MISS_V = 13'(MISS_MS);
  localparam logic [10:0] WAIT_V = 11'(WAIT_MIN_TICKS);
  // Loaded on entry so that the count reaching zero marks the last hold cycle.
  localparam logic [10:0] HOLD_V = 11'(HOLD_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [10:0] delay_q, delay_d;
  logic [10:0] hold_q, hold_d;
  logic [12:0] elapsed_q, elapsed_d;
  logic [12:0] number_q, number_d;
  logic        select_q, select_d;
  logic [1:0]  mode_q, mode_d;
  logic        led_go_q, led_go_d;
  logic        foul_q, foul_d;
  logic        miss_q, miss_d;
  logic [12:0] best_q, best_d;
  logic        do_arm, do_idle;

  function automatic logic [1:0] map_mode(input logic [1:0] sel);
    return (sel == 2'b11) ? 2'b10 : sel;
  endfunction

  function automatic logic [12:0] timeout_of(input logic [1:0] m);
    case (m)
      2'b00:   return 13'(TO_EASY_MS);
      2'b01:   return 13'(TO_REG_MS);
      default: return 13'(TO_HARD_MS);
    endcase
  endfunction

  function automatic logic [12:0] sat_add2(input logic [12:0] e);
    logic [13:0] s;
    s = {1'b0, e} + 14'd2;
    if (s >= {1'b0, MISS_V}) return MISS_V;
    return s[12:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    delay_d   = delay_q;
    hold_d    = hold_q;
    elapsed_d = elapsed_q;
    number_d  = number_q;
    select_d  = select_q;
    mode_d    = mode_q;
    led_go_d  = led_go_q;
    foul_d    = foul_q;
    miss_d    = miss_q;
    best_d    = best_q;
    do_arm    = 1'b0;
    do_idle   = 1'b0;

    case (state_q)
      S_IDLE: begin
        mode_d = map_mode(mode_sel);
        if (btn_start) do_arm = 1'b1;
      end
      S_ARM: begin
        if (btn_react) begin
          state_d  = S_FOUL;
          number_d = MISS_V;
          foul_d   = 1'b1;
          hold_d   = HOLD_V;
        end else if (delay_q == 11'd0) begin
          state_d   = S_GO;
          elapsed_d = 13'd0;
          number_d  = 13'd0;
          led_go_d  = 1'b1;
        end else begin
          delay_d = delay_q - 11'd1;
        end
      end
      S_GO: begin
        if (btn_react) begin
          state_d  = S_RESULT;
          number_d = elapsed_q;
          led_go_d = 1'b0;
          hold_d   = HOLD_V;
          if (elapsed_q < best_q) best_d = elapsed_q;
        end else if (elapsed_q >= timeout_of(mode_q)) begin
          state_d  = S_RESULT;
          number_d = MISS_V;
          miss_d   = 1'b1;
          led_go_d = 1'b0;
          hold_d   = HOLD_V;
        end else begin
          elapsed_d = sat_add2(elapsed_q);
          number_d  = sat_add2(elapsed_q);
        end
      end
      S_RESULT, S_FOUL: begin
        // Start beats hold expiry; the latched mode is kept on re-arm.
        if (btn_start)            do_arm  = 1'b1;
        else if (hold_q == 11'd0) do_idle = 1'b1;
        else                      hold_d  = hold_q - 11'd1;
      end
      default: do_idle = 1'b1;
    endcase

    if (do_arm) begin
      state_d  = S_ARM;
      delay_d  = WAIT_V + {1'b0, lfsr_q};
      select_d = 1'b1;
      number_d = 13'd0;
      led_go_d = 1'b0;
      foul_d   = 1'b0;
      miss_d   = 1'b0;
    end
    if (do_idle) begin
      state_d  = S_IDLE;
      select_d = 1'b0;
      number_d = 13'd0;
      led_go_d = 1'b0;
      foul_d   = 1'b0;
      miss_d   = 1'b0;
      mode_d   = map_mode(mode_sel);
    end
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 10'h2A5;
      delay_q   <= 11'd0;
      hold_q    <= 11'd0;
      elapsed_q <= 13'd0;
      number_q  <= 13'd0;
      select_q  <= 1'b0;
      mode_q    <= 2'b00;
      led_go_q  <= 1'b0;
      foul_q    <= 1'b0;
      miss_q    <= 1'b0;
      best_q    <= MISS_V;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      hold_q    <= hold_d;
      elapsed_q <= elapsed_d;
      number_q  <= number_d;
      select_q  <= select_d;
      mode_q    <= mode_d;
      led_go_q  <= led_go_d;
      foul_q    <= foul_d;
      miss_q    <= miss_d;
      best_q    <= best_d;
    end
  end

  assign number = number_q;
  assign select = select_q;
  assign mode   = mode_q;
  assign led_go = led_go_q;
  assign foul   = foul_q;
  assign miss   = miss_q;
  assign best   = best_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Testbench for reaction_sequencer: directed rounds followed by randomized
// rounds, all checked against a behavioural round model.
module tb_reaction_sequencer;

  logic        clk_500Hz = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [12:0] number;
  logic        select;
  logic [1:0]  mode;
  logic        led_go;
  logic        foul;
  logic        miss;
  logic [12:0] best;

  int vectors = 0;
  int miscompares = 0;

  // Round model
  logic [9:0] lfsr_m;
  int         best_m = 8190;
  logic [1:0] latched_m = 2'b00;
  bit         idle_m = 1'b1;

  reaction_sequencer dut (
    .clk_500Hz(clk_500Hz),
    .rst(rst),
    .btn_start(btn_start),
    .btn_react(btn_react),
    .mode_sel(mode_sel),
    .number(number),
    .select(select),
    .mode(mode),
    .led_go(led_go),
    .foul(foul),
    .miss(miss),
    .best(best)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  // x^10 + x^7 + 1, shifting towards the MSB
  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    int x;
    x = int'(v);
    return 10'(((x * 2) % 1024) | (((x >> 9) ^ (x >> 6)) & 1));
  endfunction

  always @(posedge clk_500Hz or posedge rst) begin
    if (rst) lfsr_m <= 10'h2A5;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  function automatic logic [1:0] map_m(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic int timeout_m(input logic [1:0] m);
    return (m == 2'd0) ? 2000 : (m == 2'd1) ? 1000 : 500;
  endfunction

  task automatic tick();
    @(posedge clk_500Hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_number"}, 32'(number), 32'd0);
    chk({tag, "_select"}, 32'(select), 32'd0);
    chk({tag, "_mode"},   32'(mode),   32'd0);
    chk({tag, "_led_go"}, 32'(led_go), 32'd0);
    chk({tag, "_foul"},   32'(foul),   32'd0);
    chk({tag, "_miss"},   32'(miss),   32'd0);
    chk({tag, "_best"},   32'(best),   32'd8190);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    btn_start = 1'b0;
    btn_react = 1'b0;
    tick();
    check_reset(tag);
    rst = 1'b0;
    best_m = 8190;
    idle_m = 1'b1;
  endtask

  task automatic start_round(output int exp_n);
    exp_n = 500 + int'(lfsr_m);
    if (idle_m) latched_m = map_m(mode_sel);
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    idle_m = 1'b0;
    chk("arm_select", 32'(select), 32'd1);
    chk("arm_number", 32'(number), 32'd0);
    chk("arm_flags",  32'({foul, miss, led_go}), 32'd0);
  endtask

  task automatic wait_go(input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!led_go && n < 2000);
    chk("arm_to_go", 32'(n), 32'(exp_n + 1));
    chk("delay_range", 32'((n - 1 >= 500) && (n - 1 <= 1523)), 32'd1);
    chk("go_mode", 32'(mode), 32'(latched_m));
    chk("go_number", 32'(number), 32'd0);
  endtask

  // React k ticks after GO entry (react sampled with elapsed = 2k unless timed out)
  task automatic go_react(input int k);
    int t, res;
    bit m;
    t = timeout_m(latched_m);
    for (int i = 0; i < k; i++) tick();
    if (k <= t / 2) begin
      chk("go_elapsed", 32'(number), 32'(2 * k));
      chk("go_led", 32'(led_go), 32'd1);
    end
    btn_react = 1'b1;
    tick();
    btn_react = 1'b0;
    if (k <= t / 2) begin
      res = 2 * k;
      m = 1'b0;
      if (res < best_m) best_m = res;
    end else begin
      res = 8190;
      m = 1'b1;
    end
    chk("result_number", 32'(number), 32'(res));
    chk("result_miss", 32'(miss), 32'(m));
    chk("result_foul", 32'(foul), 32'd0);
    chk("result_led", 32'(led_go), 32'd0);
    chk("result_best", 32'(best), 32'(best_m));
  endtask

  task automatic do_foul(input int j);
    for (int i = 0; i < j; i++) tick();
    btn_react = 1'b1;
    tick();
    btn_react = 1'b0;
    chk("foul_flag", 32'(foul), 32'd1);
    chk("foul_number", 32'(number), 32'd8190);
    chk("foul_best", 32'(best), 32'(best_m));
    chk("foul_led_miss", 32'({led_go, miss}), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (select && n < 2000);
    chk("hold_len", 32'(n), 32'd1500);
    idle_m = 1'b1;
    tick();
    chk("idle_mode", 32'(mode), 32'(map_m(mode_sel)));
    chk("idle_flags", 32'({foul, miss, led_go}), 32'd0);
  endtask

  initial begin
    int n_exp;
    int r;

    // Reset values and the mode banner
    do_reset("reset");
    mode_sel = 2'b11;
    tick();
    tick();
    chk("banner_mode", 32'(mode), 32'd2);
    chk("banner_select", 32'(select), 32'd0);
    btn_react = 1'b1;
    tick();
    btn_react = 1'b0;
    chk("idle_react_ignored", 32'(select), 32'd0);

    // First start 5 cycles after reset, easy round with result 300
    mode_sel = 2'b00;
    do_reset("reset2");
    for (int i = 0; i < 5; i++) tick();
    start_round(n_exp);
    wait_go(n_exp);
    go_react(150);
    wait_idle();

    // Foul 10 ticks after start, then re-arm from FOUL
    mode_sel = 2'b01;
    start_round(n_exp);
    do_foul(10);
    start_round(n_exp);
    wait_go(n_exp);
    go_react(100);
    wait_idle();

    // Hard-mode timeout, then react exactly on the timeout cycle
    mode_sel = 2'b10;
    tick();
    start_round(n_exp);
    mode_sel = 2'b00;
    wait_go(n_exp);
    go_react(400);
    start_round(n_exp);
    wait_go(n_exp);
    go_react(250);

    // Reset in the middle of GO
    start_round(n_exp);
    wait_go(n_exp);
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led_go), 32'd0);
    chk("async_rst_best", 32'(best), 32'd8190);
    do_reset("midgo");

    // Best tracking: 400, 250, 600 with re-arm from the RESULT hold
    mode_sel = 2'b00;
    tick();
    start_round(n_exp);
    wait_go(n_exp);
    go_react(200);
    start_round(n_exp);
    wait_go(n_exp);
    go_react(125);
    start_round(n_exp);
    wait_go(n_exp);
    go_react(300);

    // Randomized rounds
    for (int rnd = 0; rnd < 20; rnd++) begin
      start_round(n_exp);
      mode_sel = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_foul(int'($urandom_range(0, 400)));
      end else begin
        wait_go(n_exp);
        go_react(int'($urandom_range(0, 600)));
      end
      if (r == 1) begin
        wait_idle();
        mode_sel = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_sequencer.md
# reaction_sequencer

Top-level game controller for the FPGA reaction game. It sequences each round: mode selection, a random arming delay, the GO window with millisecond timing, and result/foul display. It drives the display block's `number`/`select`/`mode` inputs and the GO LED, and tracks the best valid reaction time. All logic runs on the 500 Hz multiplex clock, so 1 tick = 2 ms.

## Interface

**Parameters**
- `WAIT_MIN_TICKS`, default 500: fixed part of the arming delay (1 s).
- `HOLD_TICKS`, default 1500: result/foul display hold (3 s).
- `TO_EASY_MS`, default 2000: GO timeout in easy mode.
- `TO_REG_MS`, default 1000: GO timeout in regular mode.
- `TO_HARD_MS`, default 500: GO timeout in hard mode.
- `MISS_MS`, default 8190: saturation, miss and foul value (fits in 13 bits).

**Ports**
- `clk_500Hz` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_start` in 1: debounced single-cycle start pulse.
- `btn_react` in 1: debounced single-cycle reaction pulse.
- `mode_sel` in 2: mode switches (00 easy, 01 regular, 10 hard, 11 treated as hard).
- `number` out 13: value shown when `select` = 1.
- `select` out 1: 0 = mode banner, 1 = numeric.
- `mode` out 2: latched mode, always 00/01/10.
- `led_go` out 1: GO indicator.
- `foul` out 1: false-start flag.
- `miss` out 1: timeout flag.
- `best` out 13: best valid reaction time in ms.

## Operation

- **States:** IDLE, ARM, GO, RESULT, FOUL. All outputs are registered.
- **IDLE**
  - `select`=0 and `mode` follows `mode_sel` (11 maps to 10).
  - `btn_start` latches the mode, loads the delay counter with `WAIT_MIN_TICKS` + `lfsr[9:0]`, and enters ARM.
  - `btn_react` is ignored.
- **LFSR:** 10-bit maximal (x^10+x^7+1), seed 10'h2A5 on reset. It advances every clock in every state, so the delay range is 500–1523 ticks.
- **ARM**
  - `select`=1, `number`=0. The delay counter decrements each tick.
  - `btn_react` goes to FOUL.
  - When the counter reaches 0 (and there is no react in that cycle), enter GO with elapsed cleared to 0.
- **GO**
  - `led_go`=1, `number`=elapsed. Each cycle without a react adds 2 to elapsed, saturating at `MISS_MS`.
  - On `btn_react`: result = the current elapsed value, then go to RESULT. A react on the entry cycle gives result 0.
  - If elapsed ≥ the latched-mode timeout and there is no react in that cycle: result = `MISS_MS`, `miss`=1, go to RESULT. React wins over a same-cycle timeout.
- **RESULT**
  - `number`=result.
  - On entry, if `miss`=0 and result < `best`, then `best` ← result.
  - Leaves after `HOLD_TICKS` ticks to IDLE. `btn_start` during the hold re-arms immediately (new delay loaded, mode kept).
- **FOUL**
  - `number`=`MISS_MS`, `foul`=1, `best` unchanged.
  - Exit behaviour is the same as RESULT.
- **Flag clearing:** `miss`/`foul` clear on entry to IDLE or ARM.
- **`mode` output:** reflects the latched mode in every state except IDLE.
- **`mode_sel` changes:** ignored outside IDLE.

## Timing

- **Reset values:** state IDLE, `number`=0, `select`=0, `mode`=00, `led_go`=0, `foul`=0, `miss`=0, `best`=8190, LFSR=10'h2A5, counters 0.
- **Reset mid-round:** returns to IDLE immediately and clears `best`.
- **Output latency:** outputs change on the clock edge that performs the transition, one cycle after the input pulse is sampled.
- **ARM to GO:** `led_go` rises exactly N+1 edges after the `btn_start` edge, where N is the loaded delay.
- **Hold:** exactly `HOLD_TICKS` cycles in RESULT/FOUL, then IDLE on the next edge.
- **Simultaneous pulses:**
  - IDLE: start wins.
  - ARM: react wins over delay expiry, giving FOUL.
  - RESULT: start wins over hold expiry.
- **Widths:**
  - Delay counter: 11 bits.
  - Hold counter: 11 bits.
  - Elapsed: 13 bits, computed without overflow via saturation.

## Test plan

- **Reset and banner:** assert `rst` mid-GO → all outputs at reset values. With `mode_sel`=11 in IDLE → `mode`=10, `select`=0.
- **Valid round, easy:** `btn_start`, wait for `led_go`, react 150 ticks after GO entry → `number`=300, `best`=300. After 1500 ticks → IDLE.
- **Foul:** react 10 ticks after start → FOUL, `foul`=1, `number`=8190, `best` unchanged. `btn_start` during FOUL → ARM, `foul`=0.
- **Timeout, hard:** no react → elapsed reaches 500, `miss`=1, `number`=8190, `best` unchanged. React on the timeout cycle instead → result 500, `miss`=0.
- **Delay/LFSR:** first start 5 cycles after reset → delay equals 500 + LFSR value at that cycle (checked against a reference model). Over 20 rounds all delays lie within 500–1523.
- **Best tracking:** results 400, then 250, then 600 → `best`=400, then 250, then 250. Start during RESULT hold → re-arms without passing through IDLE.
